// File: rtl/branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared types and constants for the branch redirect controller.
//   redirect_state_t : controller state (IDLE / REDIRECT)
//   STAT_W_DEFAULT   : default width of the optional statistics counters
//   INSN_ALIGN_MASK  : low target bits that must be zero for a legal target
// -----------------------------------------------------------------------------
package branch_ctrl_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redirect_state_t;

    localparam int unsigned STAT_W_DEFAULT = 32;

    localparam logic [1:0] INSN_ALIGN_MASK = 2'b11;

endpackage : branch_ctrl_pkg

// File: rtl/branch_stats_counters.sv
// -----------------------------------------------------------------------------
// branch_stats_counters
// Three free-running event counters that wrap modulo 2^STAT_W.
// Ports:
//   clock, reset_n     : core clock, asynchronous active-low reset
//   inc_taken          : count one accepted aligned taken transfer
//   inc_not_taken      : count one resolved not-taken conditional branch
//   inc_stall          : count one redirect cycle without fetch acceptance
//   stat_taken / stat_not_taken / stat_stall : counter values
// -----------------------------------------------------------------------------
module branch_stats_counters
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned STAT_W = STAT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inc_taken,
    input  logic              inc_not_taken,
    input  logic              inc_stall,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_not_taken,
    output logic [STAT_W-1:0] stat_stall
);

    logic [STAT_W-1:0] taken_q, not_taken_q, stall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_q     <= '0;
            not_taken_q <= '0;
            stall_q     <= '0;
        end else begin
            if (inc_taken)     taken_q     <= taken_q + 1'b1;
            if (inc_not_taken) not_taken_q <= not_taken_q + 1'b1;
            if (inc_stall)     stall_q     <= stall_q + 1'b1;
        end
    end

    assign stat_taken     = taken_q;
    assign stat_not_taken = not_taken_q;
    assign stat_stall     = stall_q;

endmodule : branch_stats_counters

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Turns the EX-stage control-transfer resolution into a registered redirect
// handshake to fetch, IF/ID + ID/EX flushes and a misaligned-target trap.
// Static not-taken policy: only taken transfers redirect.
// Optional macro: BRANCH_STATS_EN enables the statistics counters; without it
// the stat_* ports are tied to zero.
// Ports:
//   clock, reset_n                 : core clock, async active-low reset
//   ex_valid/ex_is_branch/ex_is_jump/ex_take_branch/ex_target : EX resolution
//   fetch_ready                    : fetch accepts the redirect this cycle
//   redirect_valid, redirect_pc    : redirect request to fetch
//   flush_if_id, flush_id_ex       : wrong-path squash
//   busy                           : redirect outstanding (hazard unit holds PC)
//   trap_misaligned, trap_tval     : one-cycle trap pulse and offending target
//   stat_taken/stat_not_taken/stat_stall : statistics counters
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAT_W = STAT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_take_branch,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              fetch_ready,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic              trap_misaligned,
    output logic [XLEN-1:0]   trap_tval,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_not_taken,
    output logic [STAT_W-1:0] stat_stall
);

    redirect_state_t state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] trap_tval_q, trap_tval_d;
    logic            trap_q, trap_d;
    logic            take;
    logic            target_aligned;

    // ex_take_branch is gated by ex_is_branch first, so an X on it while
    // ex_is_branch=0 resolves to 0 instead of propagating.
    assign take           = ex_valid & (ex_is_jump | (ex_is_branch & ex_take_branch));
    assign target_aligned = (ex_target[1:0] & INSN_ALIGN_MASK) == 2'b00;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        trap_tval_d   = trap_tval_q;
        trap_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (target_aligned) begin
                        redirect_pc_d = ex_target;
                        state_d       = REDIRECT;
                    end else begin
                        trap_d      = 1'b1;
                        trap_tval_d = ex_target;
                    end
                end
            end
            REDIRECT: begin
                // EX is on the wrong path here; only the handshake matters.
                if (fetch_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            trap_tval_q   <= '0;
            trap_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            trap_tval_q   <= trap_tval_d;
            trap_q        <= trap_d;
        end
    end

    assign redirect_valid  = (state_q == REDIRECT);
    assign flush_if_id     = redirect_valid;
    assign flush_id_ex     = redirect_valid;
    assign busy            = redirect_valid;
    assign redirect_pc     = redirect_pc_q;
    assign trap_misaligned = trap_q;
    assign trap_tval       = trap_tval_q;

`ifdef BRANCH_STATS_EN
    logic inc_taken, inc_not_taken, inc_stall;

    assign inc_taken     = (state_q == IDLE) & take & target_aligned;
    assign inc_not_taken = (state_q == IDLE) & ex_valid & ex_is_branch
                         & ~ex_take_branch & ~ex_is_jump;
    assign inc_stall     = (state_q == REDIRECT) & ~fetch_ready;

    branch_stats_counters #(
        .STAT_W (STAT_W)
    ) u_stats (
        .clock          (clock),
        .reset_n        (reset_n),
        .inc_taken      (inc_taken),
        .inc_not_taken  (inc_not_taken),
        .inc_stall      (inc_stall),
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
        .stat_stall     (stat_stall)
    );
`else
    assign stat_taken     = '0;
    assign stat_not_taken = '0;
    assign stat_stall     = '0;
`endif

endmodule : branch_redirect_ctrl

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Directed scenarios followed by randomized traffic, compared every cycle
// against a transaction-level reference model of the redirect controller.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STAT_W = 32;

    logic              clock;
    logic              reset_n;
    logic              ex_valid, ex_is_branch, ex_is_jump, ex_take_branch;
    logic [XLEN-1:0]   ex_target;
    logic              fetch_ready;
    logic              redirect_valid, flush_if_id, flush_id_ex, busy, trap_misaligned;
    logic [XLEN-1:0]   redirect_pc, trap_tval;
    logic [STAT_W-1:0] stat_taken, stat_not_taken, stat_stall;

    int total = 0;
    int bad   = 0;

    // Reference model: an outstanding-redirect record plus trap and stats.
    bit              m_pending;
    logic [XLEN-1:0] m_pc;
    bit              m_trap;
    logic [XLEN-1:0] m_tval;
    int unsigned     m_taken, m_not_taken, m_stall;
    int unsigned     redirects_seen;

    branch_redirect_ctrl #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jump      (ex_is_jump),
        .ex_take_branch  (ex_take_branch),
        .ex_target       (ex_target),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .busy            (busy),
        .trap_misaligned (trap_misaligned),
        .trap_tval       (trap_tval),
        .stat_taken      (stat_taken),
        .stat_not_taken  (stat_not_taken),
        .stat_stall      (stat_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending   = 1'b0;
        m_pc        = '0;
        m_trap      = 1'b0;
        m_tval      = '0;
        m_taken     = 0;
        m_not_taken = 0;
        m_stall     = 0;
    endtask

    // Apply the rules to the inputs the DUT just sampled at the clock edge.
    task automatic model_step();
        bit is_take;
        is_take = ex_valid && (ex_is_jump || (ex_is_branch && ex_take_branch));
        m_trap  = 1'b0;
        if (m_pending) begin
            if (fetch_ready) begin
                m_pending = 1'b0;
                redirects_seen++;
            end else begin
                m_stall++;
            end
        end else begin
            if (is_take) begin
                if (ex_target % 4 == 0) begin
                    m_pending = 1'b1;
                    m_pc      = ex_target;
                    m_taken++;
                end else begin
                    m_trap = 1'b1;
                    m_tval = ex_target;
                end
            end
            if (ex_valid && ex_is_branch && !ex_take_branch && !ex_is_jump)
                m_not_taken++;
        end
    endtask

    task automatic check_outputs();
        check("redirect_valid", 64'(redirect_valid), 64'(m_pending));
        check("flush_if_id", 64'(flush_if_id), 64'(m_pending));
        check("flush_id_ex", 64'(flush_id_ex), 64'(m_pending));
        check("busy", 64'(busy), 64'(m_pending));
        if (m_pending) check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
        check("trap_misaligned", 64'(trap_misaligned), 64'(m_trap));
        check("trap_tval", 64'(trap_tval), 64'(m_tval));
`ifdef BRANCH_STATS_EN
        check("stat_taken", 64'(stat_taken), 64'(m_taken));
        check("stat_not_taken", 64'(stat_not_taken), 64'(m_not_taken));
        check("stat_stall", 64'(stat_stall), 64'(m_stall));
`else
        check("stat_taken_tied", 64'(stat_taken), 64'd0);
        check("stat_not_taken_tied", 64'(stat_not_taken), 64'd0);
        check("stat_stall_tied", 64'(stat_stall), 64'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic b, input logic j, input logic t,
                         input logic [XLEN-1:0] tgt, input logic fr);
        ex_valid       = v;
        ex_is_branch   = b;
        ex_is_jump     = j;
        ex_take_branch = t;
        ex_target      = tgt;
        fetch_ready    = fr;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'bx, 32'h0, 1'b1);
        cycle();
    endtask

    initial begin
        logic [STAT_W-1:0] stall_before;
        int unsigned       redirects_before;

        redirects_seen = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset_n = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset_n = 1'b1;
        repeat (2) idle_cycle();

        // Taken BEQ with fetch ready: single-cycle redirect.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        cycle();
        check("beq_valid", 64'(redirect_valid), 64'd1);
        check("beq_pc", 64'(redirect_pc), 64'h100);
        idle_cycle();
        check("beq_done", 64'(redirect_valid), 64'd0);

        // JAL with fetch backpressure for three cycles.
        stall_before = stat_stall;
        drive(1'b1, 1'b0, 1'b1, 1'bx, 32'h0000_0200, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'bx, 32'h0, 1'b0);
        repeat (3) begin
            check("jal_stall_pc", 64'(redirect_pc), 64'h200);
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'bx, 32'h0, 1'b1);
        check("jal_last_valid", 64'(redirect_valid), 64'd1);
        cycle();
        check("jal_done", 64'(redirect_valid), 64'd0);
`ifdef BRANCH_STATS_EN
        check("jal_stall_count", 64'(stat_stall - stall_before), 64'd3);
`endif

        // Not-taken BNE: nothing happens.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b1);
        cycle();
        check("bne_no_redirect", 64'(redirect_valid), 64'd0);

        // Misaligned JALR: trap pulse, no redirect.
        drive(1'b1, 1'b0, 1'b1, 1'bx, 32'h0000_0102, 1'b1);
        cycle();
        check("mis_trap", 64'(trap_misaligned), 64'd1);
        check("mis_tval", 64'(trap_tval), 64'h102);
        idle_cycle();
        check("mis_pulse_end", 64'(trap_misaligned), 64'd0);

        // Wrong-path take while a redirect is outstanding.
        redirects_before = redirects_seen;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'bx, 32'h0000_0300, 1'b0);
        cycle();
        check("wrongpath_pc", 64'(redirect_pc), 64'h100);
        drive(1'b1, 1'b0, 1'b1, 1'bx, 32'h0000_0300, 1'b1);
        cycle();
        idle_cycle();
        check("wrongpath_one_redirect", 64'(redirects_seen - redirects_before), 64'd1);
        check("wrongpath_idle", 64'(redirect_valid), 64'd0);

        // Reset asserted mid-redirect, between clock edges.
        drive(1'b1, 1'b0, 1'b1, 1'bx, 32'h0000_0500, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'bx, 32'h0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 64'(redirect_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check("rst_pc", 64'(redirect_pc), 64'd0);
        check("rst_trap", 64'(trap_misaligned), 64'd0);
        #4;
        reset_n = 1'b1;
        repeat (2) idle_cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic            v, b, j, t, fr;
            logic [XLEN-1:0] tgt;
            v   = ($urandom_range(0, 3) != 0);
            b   = $urandom_range(0, 1);
            j   = ($urandom_range(0, 3) == 0);
            t   = b ? 1'($urandom_range(0, 1)) : 1'bx;
            tgt = $urandom & ~32'h3;
            if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            fr  = ($urandom_range(0, 2) != 0);
            drive(v, b, j, t, tgt, fr);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_redirect_ctrl

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control transfers for the pipelined core.
- Takes the EX-stage branch/jump resolution (branch condition from the control transfer unit, target from the ALU/adder) and drives three actions:
  - a registered redirect handshake to the fetch unit;
  - flushes of the wrong-path IF/ID and ID/EX registers;
  - a misaligned-target trap pulse.
- Sits between the EX stage, the fetch unit and the hazard unit. Static not-taken policy: only taken transfers redirect.

Parameters:
XLEN, 32, width of PC and target.
STAT_W, 32, width of each statistics counter (used only with BRANCH_STATS_EN).

Ports:
clock  in  1  core clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a valid, non-flushed instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_is_jump  in  1  EX instruction is JAL/JALR
ex_take_branch  in  1  branch condition result; sampled only when ex_is_branch=1
ex_target  in  XLEN  computed transfer target
fetch_ready  in  1  fetch unit accepts redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  new fetch PC, stable while redirect_valid=1
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
busy  out  1  controller in REDIRECT; hazard unit holds PC increment
trap_misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned
trap_tval  out  XLEN  offending target, valid with trap_misaligned
stat_taken, stat_not_taken, stat_stall  out  STAT_W each  statistics (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE. redirect_valid, flush_if_id, flush_id_ex, busy and trap_misaligned are 0. redirect_pc and trap_tval are 0. Stats counters are 0.
- take = ex_valid & (ex_is_jump | (ex_is_branch & ex_take_branch)). Jump wins if both type flags are set. ex_take_branch is don't-care when ex_is_branch=0; an X there must not propagate.
- States: IDLE, REDIRECT.
- IDLE, cycle N, take=1, ex_target[1:0]==0:
  - register redirect_pc<=ex_target; go to REDIRECT.
  - cycle N+1: redirect_valid=1, flush_if_id=1, flush_id_ex=1, busy=1.
- IDLE, cycle N, take=1, ex_target[1:0]!=0:
  - no redirect; stay IDLE.
  - cycle N+1: trap_misaligned=1 for exactly one cycle, trap_tval=ex_target. trap_tval holds its value until the next trap.
- IDLE, take=0: no action, all pulses 0.
- REDIRECT:
  - redirect_valid, busy and both flushes stay asserted each cycle.
  - Handshake completes in the cycle where redirect_valid & fetch_ready; next state IDLE, all outputs deassert next cycle.
  - Minimum redirect latency: 1 cycle after EX resolution. Penalty: 2 flushed slots plus fetch_ready wait cycles.
- In REDIRECT, EX inputs are ignored (wrong path), including a new take or misaligned target.
- redirect_pc must not change while redirect_valid=1.
- fetch_ready already high on entry to REDIRECT: single-cycle REDIRECT.
- Back-to-back: a take in the cycle the handshake completes is ignored (the EX instruction is wrong path). A take in the first IDLE cycle afterwards is accepted normally.
- Reset asserted in REDIRECT: immediate return to IDLE, request dropped, no trap.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - stat_taken increments on each accepted aligned take, including jumps.
  - stat_not_taken increments on each IDLE cycle with ex_valid & ex_is_branch & !ex_take_branch & !ex_is_jump.
  - stat_stall increments each REDIRECT cycle with fetch_ready=0.
  - Counters wrap modulo 2^STAT_W; no saturation.
- Undefined: stat ports present but tied to 0; no counter flops synthesized.

Decomposition:
- Shared package branch_ctrl_pkg: enum redirect_state_t {IDLE, REDIRECT}, default STAT_W, alignment mask constant INSN_ALIGN_MASK=2'b11.
- One sub-module, branch_stats_counters: three STAT_W counters with increment enables. Instantiated only under BRANCH_STATS_EN.

Test Plan:
- Taken BEQ: ex_valid=1, is_branch=1, take=1, target=0x0000_0100, fetch_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x100, both flushes=1 for 1 cycle; IDLE after.
- Fetch backpressure: JAL target=0x200, fetch_ready low 3 cycles then high -> redirect_valid high 4 cycles, redirect_pc stable; stat_stall=3 (stats on).
- Not-taken BNE: is_branch=1, take=0 -> no redirect, no flush; stat_not_taken +1.
- Misaligned: JALR target=0x0000_0102 -> trap_misaligned pulse 1 cycle, trap_tval=0x102, no redirect_valid.
- Wrong-path ignore: take with target 0x300 while in REDIRECT for 0x100 -> redirect_pc stays 0x100; only 1 redirect issued.
- Reset mid-redirect: reset_n low while fetch_ready=0 in REDIRECT -> all outputs 0 asynchronously; after release IDLE, no pending redirect.
